// File: rtl/target_readout_pkg.sv
// ---------------------------------------------------------------------------
// target_pkg
// Shared types and constants for the target counter readout block.
//   count_t          : one 16-bit arrival count
//   readout_state_e  : readout sequencer states
//   FRAME_HDR        : default frame header byte
//   frame_len()      : number of bytes in one readout frame for nch channels
// Optional feature macro: TARGET_READOUT_CHECKSUM_EN (adds one XOR byte to
// the end of every frame, so frame_len() grows by one).
// ---------------------------------------------------------------------------
package target_pkg;

  typedef logic [15:0] count_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    COLLECT,
    SNAP,
    SEND,
    CLR
  } readout_state_e;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  // Header + mask + two bytes per channel (+ checksum when enabled).
  function automatic int frame_len(input int nch);
`ifdef TARGET_READOUT_CHECKSUM_EN
    return 3 + 2 * nch;
`else
    return 2 + 2 * nch;
`endif
  endfunction

endpackage

// File: rtl/target_readout_if.sv
// ---------------------------------------------------------------------------
// target_readout_if
// Byte stream from the readout block toward the host UART/SPI bridge.
//   tx_data  : frame byte
//   tx_valid : tx_data is valid
//   tx_ready : sink accepts the byte when tx_valid & tx_ready
// master modport: the readout block (drives data/valid).
// slave modport : the host bridge (drives ready).
// ---------------------------------------------------------------------------
interface target_readout_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/target_readout_byte_mux.sv
// ---------------------------------------------------------------------------
// target_byte_mux
// Combinational selection of one frame byte from the frozen snapshot.
// Frame layout: HDR, mask, then per channel 0..NCH-1 the high byte followed
// by the low byte of its count. With TARGET_READOUT_CHECKSUM_EN defined a
// final byte holds the XOR of every preceding frame byte (HDR included).
// Ports:
//   shadow_i : snapshot of all counts, channel i at [i*16 +: 16]
//   mask_i   : snapshot channel mask
//   idx_i    : frame byte index to present
//   byte_o   : selected byte (0 for indices past the end of the frame)
// ---------------------------------------------------------------------------
module target_byte_mux
  import target_pkg::*;
#(
  parameter int         NCH = 8,
  parameter logic [7:0] HDR = FRAME_HDR
) (
  input  logic [NCH*16-1:0]                    shadow_i,
  input  logic [7:0]                           mask_i,
  input  logic [$clog2(frame_len(NCH)+1)-1:0]  idx_i,
  output logic [7:0]                           byte_o
);

  localparam int FLEN = frame_len(NCH);
  localparam int IW   = $clog2(FLEN + 1);

  logic [7:0] frame_bytes [FLEN];

  assign frame_bytes[0] = HDR;
  assign frame_bytes[1] = mask_i;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      count_t ch_word;
      assign ch_word                = shadow_i[gi*16 +: 16];
      assign frame_bytes[2 + 2*gi]  = ch_word[15:8];
      assign frame_bytes[3 + 2*gi]  = ch_word[7:0];
    end
  endgenerate

`ifdef TARGET_READOUT_CHECKSUM_EN
  // Folded straight from the sources rather than from frame_bytes so the
  // array has no combinational path back into itself.
  logic [7:0] cks;
  always_comb begin
    cks = HDR ^ mask_i;
    for (int c = 0; c < NCH; c++) begin
      cks = cks ^ shadow_i[c*16 + 8 +: 8] ^ shadow_i[c*16 +: 8];
    end
  end
  assign frame_bytes[FLEN-1] = cks;
`endif

  always_comb begin
    byte_o = 8'h00;
    for (int b = 0; b < FLEN; b++) begin
      if (idx_i == IW'(b)) begin
        byte_o = frame_bytes[b];
      end
    end
  end

endmodule

// File: rtl/target_readout.sv
// ---------------------------------------------------------------------------
// target_readout
// Reader side of the per-sensor timing counters. After arm, waits for a shot
// (any run flag high), waits for all channels to stop (or a timeout), freezes
// every count into a shadow register, streams the frame over the tx byte
// interface and finally pulses clear toward the counter bank.
// Optional feature macro: TARGET_READOUT_CHECKSUM_EN (XOR byte at frame end,
// implemented entirely inside target_byte_mux).
// Ports:
//   clk       : system clock
//   ares      : synchronous active-high reset
//   arm       : one-cycle request to await the next shot (only seen in IDLE)
//   run       : per-channel run flags from the counters
//   count     : packed counts, channel i at [i*CW +: CW]
//   tx        : byte stream master (tx_data / tx_valid / tx_ready)
//   clear     : one-cycle pulse to the counters' clear input
//   busy      : high in every state except IDLE
//   timed_out : last snapshot was forced by TIMEOUT (held until next snapshot)
// ---------------------------------------------------------------------------
module target_readout
  import target_pkg::*;
#(
  parameter int         NCH     = 8,
  parameter int         CW      = 16,
  parameter int         TIMEOUT = 70000,
  parameter logic [7:0] HDR     = FRAME_HDR
) (
  input  logic              clk,
  input  logic              ares,
  input  logic              arm,
  input  logic [NCH-1:0]    run,
  input  logic [NCH*CW-1:0] count,
  target_readout_if.master  tx,
  output logic              clear,
  output logic              busy,
  output logic              timed_out
);

  localparam int FLEN = frame_len(NCH);
  localparam int IW   = $clog2(FLEN + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] LAST_IDX   = IW'(FLEN - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  readout_state_e      state_q;
  logic [TW-1:0]       timer_q;
  logic [IW-1:0]       idx_q;
  logic [NCH*CW-1:0]   shadow_q;
  logic [7:0]          mask_q;
  logic [7:0]          mask_d;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic                clear_q;
  logic                busy_q;
  logic                timed_out_q;

  logic                run_idle;
  logic                timer_hit;
  logic                tx_fire;
  logic [IW-1:0]       idx_inc;
  logic [7:0]          next_byte;

  assign run_idle  = (run == '0);
  assign timer_hit = (timer_q == TIMER_LAST);
  assign tx_fire   = tx_valid_q & tx.tx_ready;
  assign idx_inc   = idx_q + IW'(1);

  // A channel is reported only if it actually stopped and saw an arrival.
  // Mask bits above NCH are tied low.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      if (gi < NCH) begin : g_used
        assign mask_d[gi] = ~run[gi] & (count[gi*CW +: CW] != '0);
      end else begin : g_unused
        assign mask_d[gi] = 1'b0;
      end
    end
  endgenerate

  // Looks one byte ahead so tx_data can be reloaded on the accepting edge.
  target_byte_mux #(
    .NCH (NCH),
    .HDR (HDR)
  ) u_byte_mux (
    .shadow_i (shadow_q),
    .mask_i   (mask_q),
    .idx_i    (idx_inc),
    .byte_o   (next_byte)
  );

  always_ff @(posedge clk) begin
    if (ares) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      mask_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_q <= ARMED;
            busy_q  <= 1'b1;
          end
        end

        ARMED: begin
          timer_q <= '0;
          if (!run_idle) begin
            state_q <= COLLECT;
          end
        end

        COLLECT: begin
          timer_q <= timer_q + TW'(1);
          // All channels stopping takes priority over the timeout.
          if (run_idle) begin
            state_q     <= SNAP;
            timed_out_q <= 1'b0;
          end else if (timer_hit) begin
            state_q     <= SNAP;
            timed_out_q <= 1'b1;
          end
        end

        SNAP: begin
          shadow_q   <= count;
          mask_q     <= mask_d;
          idx_q      <= '0;
          tx_data_q  <= HDR;
          tx_valid_q <= 1'b1;
          state_q    <= SEND;
        end

        SEND: begin
          if (tx_fire) begin
            if (idx_q == LAST_IDX) begin
              idx_q      <= '0;
              tx_valid_q <= 1'b0;
              tx_data_q  <= 8'h00;
              clear_q    <= 1'b1;
              state_q    <= CLR;
            end else begin
              idx_q     <= idx_inc;
              tx_data_q <= next_byte;
            end
          end
        end

        CLR: begin
          timer_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign clear       = clear_q;
  assign busy        = busy_q;
  assign timed_out   = timed_out_q;

endmodule

// File: tb/tb_target_readout.sv
module tb_target_readout;
  import target_pkg::*;

  localparam int NCH  = 8;
  localparam int TOUT = 50;
  localparam int FLEN = frame_len(NCH);

  logic         clk = 1'b0;
  logic         ares;
  logic         arm;
  logic [7:0]   run_s;
  logic [127:0] count_s;
  logic         clear;
  logic         busy;
  logic         timed_out;
  logic [15:0]  cnt_m [8];

  int checks = 0;
  int errors = 0;

  target_readout_if tx_if();

  always #5 clk = ~clk;

  always_comb begin
    count_s = '0;
    for (int i = 0; i < NCH; i++) count_s[i*16 +: 16] = cnt_m[i];
  end

  target_readout #(
    .NCH     (NCH),
    .CW      (16),
    .TIMEOUT (TOUT),
    .HDR     (8'hA5)
  ) dut (
    .clk       (clk),
    .ares      (ares),
    .arm       (arm),
    .run       (run_s),
    .count     (count_s),
    .tx        (tx_if),
    .clear     (clear),
    .busy      (busy),
    .timed_out (timed_out)
  );

  // ---------------- reference model and shot data ----------------
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];
  logic [15:0] vals_g [8];
  int          perm_g [8];
  int          stable_err;
  int          clear_during;
  bit          col_timeout;

  // Frame as a byte list: header, mask of stopped non-zero channels,
  // big-endian counts, optional XOR of everything before it.
  task automatic build_expected(input logic [15:0] sc [8], input logic [7:0] sr);
    logic [7:0] m;
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    m = 8'h00;
    for (int i = 0; i < NCH; i++) m[i] = (!sr[i]) && (sc[i] != 16'h0);
    exp_q.push_back(m);
    for (int i = 0; i < NCH; i++) begin
      exp_q.push_back(sc[i] / 256);
      exp_q.push_back(sc[i] % 256);
    end
`ifdef TARGET_READOUT_CHECKSUM_EN
    x = 8'h00;
    foreach (exp_q[b]) x = x ^ exp_q[b];
    exp_q.push_back(x);
`else
    x = 8'h00;
`endif
  endtask

  task automatic randomize_shot();
    int r;
    int j;
    int t;
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       vals_g[i] = 16'h0000;
      else if (r == 2) vals_g[i] = 16'hFFFF;
      else             vals_g[i] = 16'($urandom_range(1, 65534));
      perm_g[i] = i;
    end
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm_g[i]; perm_g[i] = perm_g[j]; perm_g[j] = t;
    end
  endtask

  // Arms from IDLE with all channels running, then stops one channel per
  // cycle in perm_g order. Returns at the negedge where the last stop is driven.
  task automatic start_and_drop();
    for (int i = 0; i < 8; i++) cnt_m[i] = 16'h0;
    run_s = 8'hFF;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      cnt_m[perm_g[j]] = vals_g[perm_g[j]];
      run_s[perm_g[j]] = 1'b0;
      if (j < 7) @(negedge clk);
    end
  endtask

  // Sink side: mode 0 always ready, 1 random ready, 2 alternating with a
  // 5-cycle stall in front of byte 7. Returns at the negedge following the
  // acceptance of the last byte (or right after byte abort_at is offered).
  task automatic collect_frame(input int mode, input int arm_at, input int abort_at);
    int         stall = 0;
    bit         tog = 1'b1;
    bit         pend = 1'b0;
    bit         pulsed = 1'b0;
    bit         r;
    logic [7:0] pend_d = 8'h00;
    int         cyc = 0;
    got_q.delete();
    stable_err = 0;
    clear_during = 0;
    col_timeout = 1'b0;
    while (1) begin
      if (clear === 1'b1) clear_during++;
      if (pend && (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== pend_d)) stable_err++;
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = 1'($urandom_range(0, 1));
      else if (got_q.size() == 7 && stall < 5) begin r = 1'b0; stall++; end
      else begin r = tog; tog = !tog; end
      arm = 1'b0;
      if (arm_at >= 0 && !pulsed && got_q.size() == arm_at && tx_if.tx_valid === 1'b1) begin
        arm = 1'b1;
        pulsed = 1'b1;
      end
      tx_if.tx_ready = r;
      if (tx_if.tx_valid === 1'b1 && r) got_q.push_back(tx_if.tx_data);
      pend = (tx_if.tx_valid === 1'b1) && !r;
      pend_d = tx_if.tx_data;
      if (abort_at >= 0 && got_q.size() == abort_at) break;
      @(negedge clk);
      cyc++;
      if (got_q.size() >= FLEN) break;
      if (cyc >= 400) begin col_timeout = 1'b1; break; end
    end
    arm = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ares = 1'b1; arm = 1'b0; run_s = 8'h00; tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) cnt_m[i] = 16'h0;
    repeat (3) @(negedge clk);
    checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_if.tx_valid); end
    checks++; if (tx_if.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_if.tx_data); end
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL reset_clear: got %b want 0", clear); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL reset_timed_out: got %b want 0", timed_out); end
    ares = 1'b0;
    @(negedge clk);
    $display("reset: outputs idle");
  endtask

  task automatic test_normal();
    for (int i = 0; i < 8; i++) begin vals_g[i] = 16'(100 * (i + 1)); perm_g[i] = i; end
    tx_if.tx_ready = 1'b1;   // ready while nothing is valid must be harmless
    start_and_drop();
    @(negedge clk);
    checks++; if (tx_if.tx_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL normal_snap_cycle: valid=%b busy=%b want valid=0 busy=1", tx_if.tx_valid, busy); end
    @(negedge clk);
    checks++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'hA5) begin errors++; $display("FAIL normal_latency: valid=%b data=%h want valid=1 data=a5", tx_if.tx_valid, tx_if.tx_data); end
    build_expected(vals_g, 8'h00);
    collect_frame(0, -1, -1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL normal_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
      checks++; if (got_q[b] !== exp_q[b]) begin errors++; $display("FAIL normal_byte%0d: got %h want %h", b, got_q[b], exp_q[b]); end
    end
    if (got_q.size() >= 18) begin
      checks++; if (got_q[1] !== 8'hFF || got_q[3] !== 8'h64 || got_q[16] !== 8'h03 || got_q[17] !== 8'h20) begin
        errors++; $display("FAIL normal_known: mask=%h b3=%h b16=%h b17=%h want ff 64 03 20", got_q[1], got_q[3], got_q[16], got_q[17]);
      end
    end
    checks++; if (tx_if.tx_valid !== 1'b0 || clear !== 1'b1 || clear_during != 0) begin errors++; $display("FAIL normal_clear: valid=%b clear=%b early_clears=%0d want 0 1 0", tx_if.tx_valid, clear, clear_during); end
    @(negedge clk);
    checks++; if (clear !== 1'b0 || busy !== 1'b0 || timed_out !== 1'b0) begin errors++; $display("FAIL normal_idle: clear=%b busy=%b timed_out=%b want 0 0 0", clear, busy, timed_out); end
    $display("frame normal: %0d bytes", got_q.size());
  endtask

  task automatic test_timeout();
    int          first_k = -1;
    logic [15:0] base;
    logic [15:0] snap [8];
    base = 16'($urandom_range(0, 16'hFF00));
    for (int i = 0; i < 8; i++) cnt_m[i] = 16'h0;
    run_s = 8'hFF;
    arm = 1'b1;
    for (int k = 0; k <= 200; k++) begin
      if (tx_if.tx_valid === 1'b1) begin first_k = k; break; end
      if (k == 1) arm = 1'b0;
      if (k == 3) for (int i = 0; i < 8; i++) if (i != 3) begin cnt_m[i] = 16'd10; run_s[i] = 1'b0; end
      cnt_m[3] = 16'(base + k);
      @(negedge clk);
    end
    arm = 1'b0;
    checks++; if (first_k != TOUT + 3) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", first_k, TOUT + 3); end
    checks++; if (timed_out !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", timed_out); end
    for (int i = 0; i < 8; i++) snap[i] = (i == 3) ? 16'(base + TOUT + 2) : 16'd10;
    build_expected(snap, 8'h08);
    for (int i = 0; i < 8; i++) cnt_m[i] = 16'($urandom);   // must not leak into frame
    run_s = 8'($urandom);
    collect_frame(0, -1, -1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
      checks++; if (got_q[b] !== exp_q[b]) begin errors++; $display("FAIL timeout_byte%0d: got %h want %h", b, got_q[b], exp_q[b]); end
    end
    if (got_q.size() > 1) begin
      checks++; if (got_q[1] !== 8'hF7) begin errors++; $display("FAIL timeout_mask: got %h want f7", got_q[1]); end
    end
    run_s = 8'h00;
    @(negedge clk);
    checks++; if (timed_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_sticky: timed_out=%b busy=%b want 1 0", timed_out, busy); end
    $display("frame timeout: %0d bytes", got_q.size());
  endtask

  task automatic test_timeout_tie();
    int first_k = -1;
    for (int i = 0; i < 8; i++) begin cnt_m[i] = 16'h0; vals_g[i] = 16'($urandom_range(1, 65535)); end
    run_s = 8'hFF;
    arm = 1'b1;
    for (int k = 0; k <= 200; k++) begin
      if (tx_if.tx_valid === 1'b1) begin first_k = k; break; end
      if (k == 1) arm = 1'b0;
      if (k == TOUT + 1) begin
        run_s = 8'h00;
        for (int i = 0; i < 8; i++) cnt_m[i] = vals_g[i];
      end
      @(negedge clk);
    end
    arm = 1'b0;
    checks++; if (first_k != TOUT + 3) begin errors++; $display("FAIL tie_latency: got %0d want %0d", first_k, TOUT + 3); end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL tie_flag: got %b want 0", timed_out); end
    build_expected(vals_g, 8'h00);
    collect_frame(0, -1, -1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL tie_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
      checks++; if (got_q[b] !== exp_q[b]) begin errors++; $display("FAIL tie_byte%0d: got %h want %h", b, got_q[b], exp_q[b]); end
    end
    @(negedge clk);
    $display("frame timeout_tie: %0d bytes", got_q.size());
  endtask

  task automatic test_backpressure();
    randomize_shot();
    start_and_drop();
    build_expected(vals_g, 8'h00);
    collect_frame(2, -1, -1);
    checks++; if (got_q.size() != exp_q.size() || col_timeout) begin errors++; $display("FAIL bp_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
      checks++; if (got_q[b] !== exp_q[b]) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", b, got_q[b], exp_q[b]); end
    end
    checks++; if (stable_err != 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stable_err); end
    checks++; if (clear !== 1'b1 || clear_during != 0) begin errors++; $display("FAIL bp_clear: clear=%b early_clears=%0d want 1 0", clear, clear_during); end
    @(negedge clk);
    $display("frame backpressure: %0d bytes", got_q.size());
  endtask

  task automatic test_arm_ignored();
    int busy_hi = 0;
    randomize_shot();
    start_and_drop();
    build_expected(vals_g, 8'h00);
    collect_frame(0, 3, -1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL arm_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
      checks++; if (got_q[b] !== exp_q[b]) begin errors++; $display("FAIL arm_byte%0d: got %h want %h", b, got_q[b], exp_q[b]); end
    end
    @(negedge clk);
    run_s = 8'hFF;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) busy_hi++;
    end
    checks++; if (busy_hi != 0) begin errors++; $display("FAIL arm_dropped: got %0d busy cycles want 0", busy_hi); end
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arm_rearm: got busy=%b want 1", busy); end
    @(negedge clk);
    @(negedge clk);
    run_s = 8'h00;
    build_expected(vals_g, 8'h00);
    collect_frame(0, -1, -1);
    checks++; if (got_q.size() != exp_q.size() || got_q[got_q.size()-1] !== exp_q[exp_q.size()-1]) begin
      errors++; $display("FAIL arm_second_frame: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    @(negedge clk);
    $display("frame arm_ignored: %0d bytes", got_q.size());
  endtask

  task automatic test_reset_mid();
    int clr_seen = 0;
    randomize_shot();
    start_and_drop();
    collect_frame(0, -1, 5);
    ares = 1'b1;
    @(negedge clk);
    checks++; if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || clear !== 1'b0) begin
      errors++; $display("FAIL midreset_abort: valid=%b busy=%b clear=%b want 0 0 0", tx_if.tx_valid, busy, clear);
    end
    ares = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (clear !== 1'b0 || tx_if.tx_valid !== 1'b0) clr_seen++;
    end
    checks++; if (clr_seen != 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles want 0", clr_seen); end
    randomize_shot();
    start_and_drop();
    build_expected(vals_g, 8'h00);
    collect_frame(1, -1, -1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midreset_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
      checks++; if (got_q[b] !== exp_q[b]) begin errors++; $display("FAIL midreset_byte%0d: got %h want %h", b, got_q[b], exp_q[b]); end
    end
    @(negedge clk);
    $display("frame reset_mid: %0d bytes after restart", got_q.size());
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      randomize_shot();
      start_and_drop();
      build_expected(vals_g, 8'h00);
      collect_frame(1, -1, -1);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b%0d_len: got %0d want %0d", f, got_q.size(), exp_q.size()); end
      for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
        checks++; if (got_q[b] !== exp_q[b]) begin errors++; $display("FAIL b2b%0d_byte%0d: got %h want %h", f, b, got_q[b], exp_q[b]); end
      end
      checks++; if (clear !== 1'b1 || clear_during != 0) begin errors++; $display("FAIL b2b%0d_clear: clear=%b early_clears=%0d want 1 0", f, clear, clear_during); end
      @(negedge clk);
      checks++; if (timed_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b%0d_idle: timed_out=%b busy=%b want 0 0", f, timed_out, busy); end
      $display("frame back_to_back %0d: %0d bytes", f, got_q.size());
    end
  endtask

`ifdef TARGET_READOUT_CHECKSUM_EN
  task automatic test_checksum();
    for (int i = 0; i < 8; i++) begin vals_g[i] = 16'h0101; perm_g[i] = 7 - i; end
    start_and_drop();
    collect_frame(0, -1, -1);
    checks++; if (got_q.size() != 19) begin errors++; $display("FAIL cks_len: got %0d want 19", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[got_q.size()-1] !== 8'h5A) begin errors++; $display("FAIL cks_byte: got %h want 5a", got_q[got_q.size()-1]); end
    end
    @(negedge clk);
    $display("frame checksum: %0d bytes", got_q.size());
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_timeout_tie();
    test_backpressure();
    test_arm_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef TARGET_READOUT_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
